serial_tx_fsm: RTL and testbench
================================

// Module: serial_tx_fsm
// PURPOSE
//  Transmit side of the start-pulse + 1-bit serial link: accepts a parallel word
//  over a valid/ready handshake, emits a 1-cycle start pulse, then shifts the
//  word out LSB-first, one bit per clock, on the following WIDTH cycles.
//  Drives the existing serial receiver FSM (start/data_in pins) in the same clock domain.
// PARAMETERS
//  WIDTH  8  bits per frame; receiver is fixed at 8, other values for reuse only
//  GAP    1  idle cycles after last bit before tx_ready returns (>=1; covers rx DONE state)
// PORTS
//  clk       in   1      single clock, all logic on posedge
//  rst       in   1      reset, synchronous, active-low
//  tx_valid  in   1      upstream word valid
//  tx_ready  out  1      block can accept a word (high only in IDLE)
//  tx_data   in   WIDTH  parallel word, captured on accept
//  start     out  1      1-cycle frame-start pulse to receiver
//  data_out  out  1      serial bit to receiver data_in
//  busy      out  1      frame in progress (START..end of GAP/WAIT_ACK)
//  tx_done   out  1      1-cycle pulse, frame complete
//  ack_in    in   1      receiver done; port exists only with SER_ACK_EN
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, tx_ready=0, start=0, data_out=0, busy=0,
//   tx_done=0, shift reg and counters cleared; tx_ready rises the cycle after release.
//  All outputs registered. Reset mid-frame aborts: word discarded, no tx_done.
//  Accept: tx_valid && tx_ready at posedge -> tx_data loaded to shift reg; later
//   tx_data changes have no effect.
//  States: IDLE -> START -> SHIFT -> GAP (or WAIT_ACK) -> IDLE.
//  IDLE: tx_ready=1, busy=0, start=0, data_out=0; on accept -> START.
//  START (1 cycle, cycle k): start=1, data_out=0, busy=1, tx_ready=0.
//  SHIFT (WIDTH cycles, k+1..k+WIDTH): data_out=word[i], i=0..WIDTH-1; bit counter
//   width $clog2(WIDTH), leaves SHIFT when counter==WIDTH-1 (no wrap reliance).
//  GAP (GAP cycles): data_out=0; tx_done=1 in first GAP cycle only; then IDLE.
//  Receiver timing: rx samples start in cycle k, bit0 at end of k+1, bit7 at end of
//   k+8, DONE in k+9, back in IDLE k+10; tx_ready=1 in k+10 (GAP=1), so next start
//   earliest k+11. Back-to-back frames period = WIDTH+3 cycles.
//  tx_valid ignored outside IDLE; no queueing. start never asserted twice per frame.
// CONFIGURATION
//  SER_ACK_EN defined: GAP state replaced by WAIT_ACK; after last bit, hold
//   data_out=0, busy=1 until ack_in==1 at posedge; tx_done pulses the cycle after
//   ack seen, IDLE same cycle. No timeout; only reset exits a hung WAIT_ACK.
//  SER_ACK_EN undefined: ack_in port absent; fixed GAP behaviour above; GAP param used.
// STRUCTURE
//  Shared include ser_defs.vh: state encodings (S_IDLE, S_START, S_SHIFT, S_GAP,
//   S_WAIT_ACK) and SER_WIDTH_DEFAULT=8, used by both tx and rx.
//  One sub-module: ser_shift_reg (WIDTH, load/shift enable, LSB out).
//  FSM + bit/gap counters stay in serial_tx_fsm.
// TESTING
//  1 rst=0 3 cycles with tx_valid=1 -> all outputs 0, no start; tx_ready=1 cycle after release.
//  2 send 8'hA5 -> start high exactly 1 cycle, data_out 1,0,1,0,0,1,0,1 next 8
//    cycles, tx_done in cycle 9; looped into rx FSM -> rx data_out=8'hA5, rx done=1.
//  3 tx_valid held, 8'h01 then 8'hFF -> second start exactly 11 cycles after first;
//    rx captures 8'h01 then 8'hFF; tx_ready low between.
//  4 change tx_data to 8'h00 during SHIFT of 8'h3C -> serial stream still 8'h3C.
//  5 rst=0 during bit 4 of 8'hF0 -> next cycle outputs at reset values, no tx_done;
//    following frame 8'h5A transmits correctly.
//  6 SER_ACK_EN, ack_in=0 for 20 cycles after last bit -> busy=1, tx_ready=0,
//    no tx_done; ack_in=1 -> tx_done next cycle, tx_ready=1 same cycle.

Source files
------------

// File: rtl/serial_tx_fsm_pkg.sv
// Shared definitions for the start-pulse + 1-bit serial link (tx and rx sides).
// State encodings, default frame width and a counter-width helper.
package serial_tx_fsm_pkg;

  localparam int SER_WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_SHIFT    = 3'd2,
    S_GAP      = 3'd3,
    S_WAIT_ACK = 3'd4
  } ser_state_e;

  // Keeps counters at least one bit wide when the count range degenerates to 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Parallel-load, right-shifting register; presents the LSB for LSB-first serialisation.
module ser_shift_reg
  import serial_tx_fsm_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             lsb_o
);

  logic [WIDTH-1:0] word_q;

  // NOTE: the word register is cleared on reset so an aborted frame leaves no stale data behind.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word_q <= '0;
    end else if (load_i) begin
      word_q <= data_i;
    end else if (shift_i) begin
      word_q <= word_q >> 1;
    end
  end

  assign lsb_o = word_q[0];

endmodule

// File: rtl/serial_tx_fsm.sv
// Serial link transmitter: valid/ready word in, 1-cycle start pulse, then WIDTH bits LSB-first.
// Define SER_ACK_EN to replace the fixed GAP tail with a wait for the receiver's ack_in.
module serial_tx_fsm
  import serial_tx_fsm_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEFAULT,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  output logic             start,
  output logic             data_out,
  output logic             busy,
  output logic             tx_done
`ifdef SER_ACK_EN
  ,
  input  logic             ack_in
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
`ifndef SER_ACK_EN
  localparam int GW = cnt_width(GAP);
  localparam logic [GW-1:0] LAST_GAP = GW'(GAP - 1);
`endif

  ser_state_e    state_q;
  logic [CW-1:0] bit_cnt_q;
`ifndef SER_ACK_EN
  logic [GW-1:0] gap_cnt_q;
`endif
  logic          tx_ready_q;
  logic          start_q;
  logic          data_out_q;
  logic          busy_q;
  logic          tx_done_q;

  logic          accept;
  logic          shift_en;
  logic          sr_lsb;

  // tx_ready_q is only ever high in IDLE, so it alone qualifies the handshake.
  assign accept   = tx_valid && tx_ready_q;
  assign shift_en = (state_q == S_START) ||
                    ((state_q == S_SHIFT) && (bit_cnt_q != LAST_BIT));

  ser_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .shift_i (shift_en),
    .data_i  (tx_data),
    .lsb_o   (sr_lsb)
  );

  // NOTE: every register here updates with <= so all of them see the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
`ifndef SER_ACK_EN
      gap_cnt_q  <= '0;
`endif
      tx_ready_q <= 1'b0;
      start_q    <= 1'b0;
      data_out_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_done_q <= 1'b0;
          if (accept) begin
            state_q    <= S_START;
            tx_ready_q <= 1'b0;
            start_q    <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            tx_ready_q <= 1'b1;
          end
        end

        S_START: begin
          start_q    <= 1'b0;
          data_out_q <= sr_lsb;
          bit_cnt_q  <= '0;
          state_q    <= S_SHIFT;
        end

        S_SHIFT: begin
          if (bit_cnt_q == LAST_BIT) begin
            data_out_q <= 1'b0;
`ifdef SER_ACK_EN
            state_q    <= S_WAIT_ACK;
`else
            state_q    <= S_GAP;
            tx_done_q  <= 1'b1;
            gap_cnt_q  <= '0;
`endif
          end else begin
            data_out_q <= sr_lsb;
            bit_cnt_q  <= bit_cnt_q + CW'(1);
          end
        end

`ifdef SER_ACK_EN
        // No timeout by design: only reset leaves a frame whose ack never arrives.
        S_WAIT_ACK: begin
          if (ack_in) begin
            state_q    <= S_IDLE;
            tx_done_q  <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
`else
        S_GAP: begin
          tx_done_q <= 1'b0;
          if (gap_cnt_q == LAST_GAP) begin
            state_q    <= S_IDLE;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
`endif

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_ready = tx_ready_q;
  assign start    = start_q;
  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_serial_tx_fsm.sv
// Scoreboard bench for serial_tx_fsm: the driver queues accepted words, and a negedge
// monitor acting as the link receiver reassembles frames and checks the cycle-level protocol.
module tb_serial_tx_fsm;

  localparam int W      = 8;
  localparam int G      = 1;
  localparam int PERIOD = W + 2 + G;

  logic         clk      = 1'b0;
  logic         rst      = 1'b0;
  logic         tx_valid = 1'b0;
  logic [W-1:0] tx_data  = '0;
  logic         tx_ready;
  logic         start;
  logic         data_out;
  logic         busy;
  logic         tx_done;
`ifdef SER_ACK_EN
  logic         ack_in      = 1'b1;
  bit           ack_rand    = 1'b0;
  bit           ack_at_edge = 1'b0;
`endif

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_q[$];
  int           start_log[$];
  int           cyc = 0;
  int           mon_pos = -1;
  bit           rst_at_edge = 1'b0;
  logic [W-1:0] got = '0;
  logic [W-1:0] cur = '0;

  serial_tx_fsm #(
    .WIDTH (W),
    .GAP   (G)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .start    (start),
    .data_out (data_out),
    .busy     (busy),
    .tx_done  (tx_done)
`ifdef SER_ACK_EN
    ,
    .ack_in   (ack_in)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rst_at_edge <= rst;
`ifdef SER_ACK_EN
    ack_at_edge <= ack_in;
`endif
  end

`ifdef SER_ACK_EN
  always @(posedge clk) begin
    #1;
    if (ack_rand) ack_in = 1'($urandom_range(0, 1));
  end
`endif

  task automatic check(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, got_v, exp_v);
    end
  endtask

  // Receiver-side view of the link: one step per clock, outputs sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst_at_edge) begin
      check("rst_outputs", {27'd0, tx_ready, start, data_out, busy, tx_done}, 32'd0);
      mon_pos = -1;
      exp_q.delete();
    end else if (mon_pos < 0) begin
      if (start) begin
        check("start_has_word", {31'd0, exp_q.size() != 0}, 32'd1);
        check("start_cycle", {28'd0, tx_ready, data_out, busy, tx_done}, 32'b0010);
        cur = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        start_log.push_back(cyc);
        mon_pos = 0;
      end else begin
        check("idle_outputs", {28'd0, tx_ready, data_out, busy, tx_done}, 32'b1000);
      end
    end else begin
      mon_pos++;
      if (mon_pos <= W) begin
        check("shift_ctrl", {28'd0, tx_ready, start, busy, tx_done}, 32'b0010);
        got[mon_pos-1] = data_out;
        if (mon_pos == W) check("frame_word", {24'd0, got}, {24'd0, cur});
      end else begin
`ifdef SER_ACK_EN
        if (mon_pos > W + 1 && ack_at_edge) begin
          check("ack_done", {27'd0, tx_ready, start, data_out, busy, tx_done}, 32'b10001);
          mon_pos = -1;
        end else begin
          check("wait_ack", {27'd0, tx_ready, start, data_out, busy, tx_done}, 32'b00010);
        end
`else
        if (mon_pos <= W + G) begin
          check("gap", {27'd0, tx_ready, start, data_out, busy, tx_done},
                {27'd0, 4'b0001, 1'(mon_pos == W + 1)});
        end else begin
          check("ready_after_gap", {27'd0, tx_ready, start, data_out, busy, tx_done}, 32'b10000);
          mon_pos = -1;
        end
`endif
      end
    end
  end

  // Offers a word from posedge+1 and returns posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] w, input bit hold);
    int t = 0;
    tx_valid = 1'b1;
    tx_data  = w;
    @(negedge clk);
    while (!tx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready) begin
      check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
      tx_valid = 1'b0;
      return;
    end
    exp_q.push_back(w);
    @(posedge clk);
    #1;
    tx_valid = hold;
    tx_data  = W'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((mon_pos >= 0 || exp_q.size() != 0) && t < 300);
    if (t >= 300) check("idle_timeout", mon_pos, -1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;

    // Reset with tx_valid asserted: nothing may start.
    rst      = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b1;
    tx_valid = 1'b0;
    @(posedge clk);
    #1;

    send(8'hA5, 1'b0);
    wait_idle();

    // tx_valid held across two words: second start exactly PERIOD cycles later.
    send(8'h01, 1'b1);
    send(8'hFF, 1'b0);
    wait_idle();
    n = start_log.size();
    if (n >= 2) check("b2b_period", start_log[n-1] - start_log[n-2], PERIOD);
    else check("b2b_starts", n, 2);

    // Input word changes after accept must not reach the line.
    send(8'h3C, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    tx_data = 8'h00;
    wait_idle();

    // Reset during bit 4 aborts the frame; the next frame is clean.
    send(8'hF0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    send(8'h5A, 1'b0);
    wait_idle();

`ifdef SER_ACK_EN
    ack_in = 1'b0;
    send(8'hC3, 1'b0);
    repeat (W + 1 + 20) @(posedge clk);
    @(negedge clk);
    check("ack_hold", {29'd0, busy, tx_ready, tx_done}, 32'b100);
    @(posedge clk);
    #1;
    ack_in = 1'b1;
    wait_idle();
    ack_rand = 1'b1;
`endif

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(W'($urandom), 1'b0);
    end

`ifdef SER_ACK_EN
    @(posedge clk);
    #1;
    ack_rand = 1'b0;
    ack_in   = 1'b1;
`endif
    wait_idle();
    check("drain_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
